// File: rtl/l_eject_buffer.sv
// Local-port eject buffer: FIFOs crossbar flits toward the PE, returns credit to the L arbiter,
// pulses change-order at each packet end and flags wormhole lock violations. 1-cycle latency, no bypass.
module l_eject_buffer #(
    parameter int FLIT_W    = 32,
    parameter int DEPTH     = 4,
    parameter int PKT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FLIT_W-1:0]    xb_flit_i,
    input  logic                 xb_valid_i,
    input  logic [2:0]           xb_src_i,
    output logic                 credit_o,
    output logic                 change_order_o,
    output logic [FLIT_W-1:0]    pe_flit_o,
    output logic                 pe_valid_o,
    input  logic                 pe_ready_i,
    output logic [PKT_CNT_W-1:0] pkt_count_o,
    output logic                 overflow_o,
    output logic                 src_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] SRC_NONE = 3'b100;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    state_t            state;
    logic [2:0]        lock_src;
    logic [1:0]        ftype;
    logic              wr_en, rd_en, bad_src;

    assign credit_o   = (count < CW'(DEPTH));
    assign pe_valid_o = (count != '0);
    assign pe_flit_o  = mem[rd_ptr];
    assign wr_en      = xb_valid_i & credit_o;
    assign rd_en      = pe_valid_o & pe_ready_i;
    assign ftype      = xb_flit_i[FLIT_W-1 -: 2];

    // Type bit 1 marks a packet start (head/single), bit 0 a packet end (tail/single).
    assign bad_src = (state == IDLE) ? !ftype[1]
                                     : (ftype[1] || (xb_src_i != lock_src));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            state          <= IDLE;
            lock_src       <= SRC_NONE;
            change_order_o <= 1'b0;
            pkt_count_o    <= '0;
            overflow_o     <= 1'b0;
            src_err_o      <= 1'b0;
        end else begin
            change_order_o <= 1'b0;
            if (xb_valid_i && !credit_o) overflow_o <= 1'b1;
            if (wr_en) begin
                mem[wr_ptr] <= xb_flit_i;
                wr_ptr      <= wr_ptr + AW'(1);
                if (bad_src) src_err_o <= 1'b1;
                if (ftype[0]) begin
                    state          <= IDLE;
                    lock_src       <= SRC_NONE;
                    change_order_o <= 1'b1;
                    pkt_count_o    <= pkt_count_o + PKT_CNT_W'(1);
                end else if (ftype[1]) begin
                    state    <= BUSY;
                    lock_src <= xb_src_i;
                end
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_l_eject_buffer.sv
// Scoreboard bench for l_eject_buffer: expected flits are queued at issue, a negedge monitor checks deliveries.
module tb_l_eject_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] xb_flit = '0;
    logic        xb_valid = 1'b0;
    logic [2:0]  xb_src = 3'b100;
    logic        credit, change_order, pe_valid, pe_ready = 1'b0;
    logic [31:0] pe_flit;
    logic [7:0]  pkt_count;
    logic        overflow, src_err;

    int          checks = 0;
    int          failures = 0;
    int          co_cnt = 0;
    int          co_base;
    logic [31:0] exp_q[$];

    l_eject_buffer #(.FLIT_W(32), .DEPTH(4), .PKT_CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .xb_flit_i(xb_flit), .xb_valid_i(xb_valid), .xb_src_i(xb_src),
        .credit_o(credit), .change_order_o(change_order),
        .pe_flit_o(pe_flit), .pe_valid_o(pe_valid), .pe_ready_i(pe_ready),
        .pkt_count_o(pkt_count), .overflow_o(overflow), .src_err_o(src_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and counts change-order pulses.
    always @(negedge clk) begin
        if (reset) begin
            if (change_order) co_cnt++;
            if (pe_valid && pe_ready) begin
                if (exp_q.size() == 0) chk("unexpected_flit", pe_flit, 32'hxxxx_xxxx);
                else chk("pe_flit", pe_flit, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] f, input logic [2:0] s,
                       input logic exp_acc, input string nm);
        xb_valid = v;
        xb_flit  = f;
        xb_src   = s;
        if (v) begin
            chk({nm, "_credit"}, {31'd0, credit}, {31'd0, exp_acc});
            if (exp_acc) exp_q.push_back(f);
        end
        @(posedge clk);
        #1;
        xb_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and idle state
        do_reset();
        chk("rst_credit", {31'd0, credit}, 32'd1);
        chk("rst_valid", {31'd0, pe_valid}, 32'd0);
        chk("rst_flit", pe_flit, 32'd0);
        chk("rst_pkt", {24'd0, pkt_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_co", {31'd0, change_order}, 32'd0);

        // Head/body/tail from W with the PE always ready
        pe_ready = 1'b1;
        co_base = co_cnt;
        cyc(1, 32'h8000_00A1, 3'b010, 1, "w_head");
        chk("lat_valid", {31'd0, pe_valid}, 32'd1);
        chk("lat_flit", pe_flit, 32'h8000_00A1);
        cyc(1, 32'h0000_00A2, 3'b010, 1, "w_body");
        cyc(1, 32'h4000_00A3, 3'b010, 1, "w_tail");
        chk("w_co_pulse", {31'd0, change_order}, 32'd1);
        chk("w_pkt", {24'd0, pkt_count}, 32'd1);
        cyc(0, 0, 3'b100, 0, "idle");
        chk("w_co_drop", {31'd0, change_order}, 32'd0);
        chk("w_srcerr", {31'd0, src_err}, 32'd0);
        cyc(0, 0, 3'b100, 0, "idle");
        chk("w_pulses", co_cnt - co_base, 32'd1);
        chk("w_drained", exp_q.size(), 32'd0);

        // Fill with the PE stalled, fifth write overflows
        pe_ready = 1'b0;
        co_base = co_cnt;
        for (int i = 1; i <= 5; i++)
            cyc(1, 32'hC000_0000 | i, 3'b100, (i <= 4), "fill");
        chk("full_ovf", {31'd0, overflow}, 32'd1);
        chk("full_valid", {31'd0, pe_valid}, 32'd1);
        chk("full_head", pe_flit, 32'hC000_0001);
        chk("full_pkt", {24'd0, pkt_count}, 32'd5);

        // Simultaneous write and pop while full: write refused
        pe_ready = 1'b1;
        cyc(1, 32'hC000_0009, 3'b100, 0, "full_rw");
        chk("pop_credit", {31'd0, credit}, 32'd1);
        chk("pop_ovf", {31'd0, overflow}, 32'd1);
        repeat (5) cyc(0, 0, 3'b100, 0, "idle");
        chk("full_pulses", co_cnt - co_base, 32'd4);
        chk("full_drained", exp_q.size(), 32'd0);
        chk("full_valid_end", {31'd0, pe_valid}, 32'd0);

        // Lock violation: head from N, body from S, then a single
        co_base = co_cnt;
        cyc(1, 32'h8000_0010, 3'b000, 1, "n_head");
        chk("n_srcerr0", {31'd0, src_err}, 32'd0);
        cyc(1, 32'h0000_0011, 3'b001, 1, "s_body");
        chk("s_srcerr", {31'd0, src_err}, 32'd1);
        cyc(1, 32'hC000_0012, 3'b000, 1, "single");
        chk("single_co", {31'd0, change_order}, 32'd1);
        chk("single_pkt", {24'd0, pkt_count}, 32'd6);
        repeat (3) cyc(0, 0, 3'b100, 0, "idle");
        chk("srcerr_sticky", {31'd0, src_err}, 32'd1);
        chk("err_pulses", co_cnt - co_base, 32'd1);
        chk("err_drained", exp_q.size(), 32'd0);

        // 256 back-to-back singles wrap the packet counter
        do_reset();
        chk("rst2_srcerr", {31'd0, src_err}, 32'd0);
        chk("rst2_ovf", {31'd0, overflow}, 32'd0);
        co_base = co_cnt;
        for (int i = 0; i < 256; i++) begin
            cyc(1, 32'hC000_1000 | i, 3'b011, 1, "burst");
            if (i == 127) chk("burst_pkt128", {24'd0, pkt_count}, 32'd128);
        end
        chk("burst_pkt_wrap", {24'd0, pkt_count}, 32'd0);
        repeat (2) cyc(0, 0, 3'b100, 0, "idle");
        chk("burst_pulses", co_cnt - co_base, 32'd256);
        chk("burst_drained", exp_q.size(), 32'd0);

        // Asynchronous reset with two flits of a packet buffered
        pe_ready = 1'b0;
        cyc(1, 32'h8000_0020, 3'b011, 1, "r_head");
        cyc(1, 32'h0000_0021, 3'b011, 1, "r_body");
        chk("pre_rst_valid", {31'd0, pe_valid}, 32'd1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", {31'd0, pe_valid}, 32'd0);
        chk("arst_credit", {31'd0, credit}, 32'd1);
        chk("arst_flit", pe_flit, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Lock was discarded: a body now arrives in IDLE and is flagged
        pe_ready = 1'b1;
        cyc(1, 32'h0000_0022, 3'b011, 1, "idle_body");
        chk("idle_body_err", {31'd0, src_err}, 32'd1);
        repeat (2) cyc(0, 0, 3'b100, 0, "idle");
        chk("final_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l_eject_buffer.md
Name: l_eject_buffer

Overview:
- Sink end of the local (L) output port of a mesh NoC router: consumes flits that the L-port round-robin arbiter grants through the crossbar and delivers them to the attached processing element (PE) through a valid/ready interface.
- Buffers flits in a FIFO and generates the downstream-credit signal the L arbiter uses.
- Pulses the arbiter's change-order input at the end of every packet.
- Enforces wormhole packet lock: all flits of one packet must come from one source port.

Parameters:
- FLIT_W, 32, flit width in bits; bits [FLIT_W-1:FLIT_W-2] are the flit type.
- DEPTH, 4, FIFO depth in flits; power of two, minimum 2.
- PKT_CNT_W, 8, width of the delivered-packet counter.

Ports:
- clk  input  1  router clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- xb_flit_i  input  FLIT_W  flit from the crossbar L output.
- xb_valid_i  input  1  xb_flit_i is valid this cycle.
- xb_src_i  input  3  source select from the arbiter: 000=N, 001=S, 010=W, 011=E, 100=none.
- credit_o  output  1  space available; drives the L arbiter's downstream-credit input.
- change_order_o  output  1  one-cycle pulse; drives the L arbiter's change-order input.
- pe_flit_o  output  FLIT_W  flit at the FIFO head.
- pe_valid_o  output  1  pe_flit_o is valid.
- pe_ready_i  input  1  PE accepts pe_flit_o.
- pkt_count_o  output  PKT_CNT_W  count of tail/single flits accepted, wrapping.
- overflow_o  output  1  sticky: a write was attempted while credit_o=0.
- src_err_o  output  1  sticky: a flit arrived from a source other than the locked one.

Behaviour:
- Flit types:
  - 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head and tail).
- Reset (async assert, sync deassert):
  - FIFO empty, count=0, read/write pointers=0, state IDLE, locked source=100.
  - credit_o=1, change_order_o=0, pe_valid_o=0, pe_flit_o=0, pkt_count_o=0, overflow_o=0, src_err_o=0.
  - Reset asserted mid-packet discards all buffered flits and the lock.
- Write:
  - Accepted when xb_valid_i=1 and credit_o=1.
  - The flit is stored at wr_ptr; the pointer wraps modulo DEPTH.
- Credit:
  - credit_o = (count < DEPTH), combinational from the registered count only.
  - It is independent of pe_ready_i, so a full FIFO with a simultaneous read still refuses the write that cycle.
  - credit_o reasserts the cycle after a pop from full.
- Overflow:
  - xb_valid_i=1 while credit_o=0 drops the flit and sets overflow_o (sticky until reset).
  - FIFO contents and state are unchanged.
- Read:
  - pe_valid_o = (count != 0); pe_flit_o = mem[rd_ptr].
  - A pop occurs when pe_valid_o and pe_ready_i are both 1.
  - pe_flit_o is held stable while pe_valid_o=1 and pe_ready_i=0.
- Count:
  - count increments on write-only, decrements on pop-only, and is unchanged on simultaneous write and pop.
  - Width is clog2(DEPTH)+1.
- FSM (on accepted writes):
  - IDLE:
    - head → BUSY; locked source = xb_src_i.
    - single → stay IDLE; pulse change_order_o.
    - body or tail in IDLE → flit accepted, src_err_o set.
  - BUSY:
    - body → stay.
    - tail → IDLE; pulse change_order_o; locked source = 100.
    - head or single in BUSY → src_err_o set, treated as its type (restarts the lock).
  - Any flit in BUSY with xb_src_i != locked source sets src_err_o; the flit is still stored.
- change_order_o:
  - Registered; high exactly one cycle, in the cycle after the accepting edge of a tail/single flit.
  - Back-to-back singles produce consecutive pulses.
- pkt_count_o:
  - Increments in the same cycle that change_order_o is set.
  - Wraps from 2^PKT_CNT_W-1 to 0.
- Latency: a flit written at edge k is visible on pe_flit_o/pe_valid_o after edge k (one cycle). There is no bypass.
- Delivery order equals acceptance order.

Test Plan:
- Reset then idle → credit_o=1, pe_valid_o=0, pkt_count_o=0; assert reset mid-packet with 2 flits buffered → count=0, pe_valid_o=0 immediately, state IDLE.
- Packet head/body/tail from W (src=010), pe_ready_i=1 → same three flits appear on pe_flit_o one cycle later each; change_order_o high the cycle after tail write; pkt_count_o=1; src_err_o=0.
- pe_ready_i=0, 5 consecutive writes with DEPTH=4 → 4 accepted, credit_o=0 after the 4th, 5th dropped, overflow_o=1; raise pe_ready_i → data 1..4 in order, credit_o=1 the cycle after the first pop.
- Full FIFO, simultaneous xb_valid_i=1 and pop → write refused, count becomes 3, overflow_o=1.
- Head from N (000), then body with src=S (001) → src_err_o=1 sticky, body still delivered; subsequent single flit raises a change_order_o pulse.
- 256 single flits with PKT_CNT_W=8 → 256 change_order_o pulses, pkt_count_o wraps to 0.
